// File: rtl/gshare_bht.sv
// Gshare direction predictor: 2-bit counter PHT indexed by PC ^ speculative global history.
// Lookup is 0-cycle combinational, training/recovery land on the next edge; no backpressure.
module gshare_bht #(
    parameter int PC_WIDTH  = 13,
    parameter int GHR_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    input  logic                 btb_hit,
    output logic                 predict_taken,
    output logic [GHR_WIDTH-1:0] lookup_ghr,
    input  logic                 update_valid,
    input  logic [PC_WIDTH-1:0]  update_pc,
    input  logic [GHR_WIDTH-1:0] update_ghr,
    input  logic                 update_taken,
    input  logic                 update_mispredict,
    output logic [CNT_WIDTH-1:0] mispredict_count
);
    localparam int ENTRIES = 1 << GHR_WIDTH;

    logic [1:0]           pht [ENTRIES];
    logic [GHR_WIDTH-1:0] ghr_spec;
    logic [GHR_WIDTH-1:0] idx_l;
    logic [GHR_WIDTH-1:0] idx_u;
    logic [1:0]           cnt_u;
    logic [1:0]           cnt_next;
    logic                 unused_pc_bits;

    // PC bits above the index alias by design.
    assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:GHR_WIDTH], update_pc[PC_WIDTH-1:GHR_WIDTH]};

    assign idx_l         = lookup_pc[GHR_WIDTH-1:0] ^ ghr_spec;
    assign idx_u         = update_pc[GHR_WIDTH-1:0] ^ update_ghr;
    assign predict_taken = lookup_valid & btb_hit & pht[idx_l][1];
    assign lookup_ghr    = ghr_spec;

    always_comb begin
        cnt_u    = pht[idx_u];
        cnt_next = cnt_u;
        if (update_taken) begin
            if (cnt_u != 2'b11) cnt_next = cnt_u + 2'b01;
        end else begin
            if (cnt_u != 2'b00) cnt_next = cnt_u - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
            ghr_spec         <= '0;
            mispredict_count <= '0;
        end else begin
            if (update_valid) pht[idx_u] <= cnt_next;
            // A mispredict means this cycle's fetch is wrong-path, so restore beats shift.
            if (update_valid && update_mispredict) begin
                ghr_spec         <= {update_ghr[GHR_WIDTH-2:0], update_taken};
                mispredict_count <= mispredict_count + 1'b1;
            end else if (lookup_valid && btb_hit) begin
                ghr_spec <= {ghr_spec[GHR_WIDTH-2:0], predict_taken};
            end
        end
    end
endmodule
